// File: rtl/instr_sequencer_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode decode helper.
package instr_sequencer_pkg;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic op_is_stop(input logic [1:0] op);
    logic stop;
    stop = 1'b0;
    case (op)
      OP_ADD, OP_LOAD, OP_STORE: stop = 1'b0;
      OP_STOP:                   stop = 1'b1;
      default:                   stop = 1'b0;
    endcase
    return stop;
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program memory: synchronous write port, combinational read port, contents never reset.
module prog_mem #(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 5
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches program words from prog_mem and streams them out
// over a valid/ready port until a stop opcode, end of memory, or abort.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 32,
  parameter int LOOP    = 0,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               abort,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  address,
  output logic               busy,
  output logic               done,
  output logic               overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  address_q, address_d;
  logic [INSTR_W-1:0] instruction_q, instruction_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               overrun_q, overrun_d;
  logic               ovr_pend_q, ovr_pend_d;

  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_we;
  logic               can_fetch;
  logic               handshake;
  logic               word_stop;
  logic               at_last;

  // Loading is only allowed while idle so a running program can never be altered.
  assign mem_we = prog_we && (state_q == ST_IDLE);

  prog_mem #(
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_prog_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (mem_rdata)
  );

  assign can_fetch = !valid_q || instr_ready;
  assign handshake = valid_q && instr_ready;
  assign word_stop = op_is_stop(mem_rdata[INSTR_W-1 -: 2]);
  assign at_last   = (pc_q == LAST_ADDR);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    address_d     = address_q;
    instruction_d = instruction_q;
    valid_d       = valid_q;
    done_d        = 1'b0;
    overrun_d     = overrun_q;
    ovr_pend_d    = ovr_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d       = '0;
          overrun_d  = 1'b0;
          ovr_pend_d = 1'b0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (can_fetch) begin
          instruction_d = mem_rdata;
          address_d     = pc_q;
          valid_d       = 1'b1;
          pc_d          = pc_q + 1'b1;
          if (word_stop) begin
            state_d = ST_DRAIN;
          end else if (at_last) begin
            if (LOOP != 0) begin
              pc_d = '0;
            end else begin
              state_d    = ST_DRAIN;
              ovr_pend_d = 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (handshake) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
          if (ovr_pend_q) begin
            overrun_d = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a start in the same cycle.
    if (abort) begin
      state_d       = ST_IDLE;
      pc_d          = pc_q;
      address_d     = address_q;
      instruction_d = instruction_q;
      valid_d       = 1'b0;
      done_d        = 1'b0;
      overrun_d     = overrun_q;
      ovr_pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      address_q     <= '0;
      instruction_q <= '0;
      valid_q       <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_pend_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      address_q     <= address_d;
      instruction_q <= instruction_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      ovr_pend_q    <= ovr_pend_d;
    end
  end

  assign instr_valid = valid_q;
  assign instruction = instruction_q;
  assign address     = address_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench: table-driven vectors, directed corner sequences, and a randomized run on a
// 4-entry no-loop instance checked against a transaction-level scoreboard.
`timescale 1ns/1ps
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  logic       clk;
  logic       clear;
  logic       prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       abort;
  logic       ready;

  logic       m_valid, m_busy, m_done, m_ovr;
  logic [7:0] m_instr;
  logic [4:0] m_addr;
  logic       o_valid, o_busy, o_done, o_ovr;
  logic [7:0] o_instr;
  logic [1:0] o_addr;
  logic       l_valid, l_busy, l_done, l_ovr;
  logic [7:0] l_instr;
  logic [1:0] l_addr;

  int checks = 0;
  int errors = 0;

  instr_sequencer #(.INSTR_W(8), .DEPTH(32), .LOOP(0)) u_main (
    .clk(clk), .clear(clear), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .abort(abort), .instr_ready(ready),
    .instr_valid(m_valid), .instruction(m_instr), .address(m_addr),
    .busy(m_busy), .done(m_done), .overrun(m_ovr)
  );

  instr_sequencer #(.INSTR_W(8), .DEPTH(4), .LOOP(0)) u_ov (
    .clk(clk), .clear(clear), .prog_we(prog_we), .prog_addr(prog_addr[1:0]),
    .prog_data(prog_data), .start(start), .abort(abort), .instr_ready(ready),
    .instr_valid(o_valid), .instruction(o_instr), .address(o_addr),
    .busy(o_busy), .done(o_done), .overrun(o_ovr)
  );

  instr_sequencer #(.INSTR_W(8), .DEPTH(4), .LOOP(1)) u_lp (
    .clk(clk), .clear(clear), .prog_we(prog_we), .prog_addr(prog_addr[1:0]),
    .prog_data(prog_data), .start(start), .abort(abort), .instr_ready(ready),
    .instr_valid(l_valid), .instruction(l_instr), .address(l_addr),
    .busy(l_busy), .done(l_done), .overrun(l_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       s;
    logic       r;
    logic       ev;
    logic [7:0] ei;
    logic [4:0] ea;
    logic       eb;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] got_w[$];
  logic [4:0] got_a[$];
  int         got_done;
  logic [7:0] ew[$];
  logic [4:0] ea_q[$];

  function automatic vec_t mk(input logic s, input logic r, input logic ev,
                              input logic [7:0] ei, input logic [4:0] ea,
                              input logic eb, input logic ed);
    vec_t v;
    v.s = s; v.r = r; v.ev = ev; v.ei = ei; v.ea = ea; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic load_std();
    load(5'd0, 8'h45); load(5'd1, 8'h59); load(5'd2, 8'h18); load(5'd3, 8'hC3);
  endtask

  // Records every handshake and done pulse of one instance over a fixed window.
  task automatic collect(input int which, input int ncyc);
    got_w.delete(); got_a.delete(); got_done = 0;
    for (int c = 0; c < ncyc; c++) begin
      logic       v, d;
      logic [7:0] w;
      logic [4:0] a;
      case (which)
        0:       begin v = m_valid; w = m_instr; a = m_addr;         d = m_done; end
        1:       begin v = o_valid; w = o_instr; a = {3'b0, o_addr}; d = o_done; end
        default: begin v = l_valid; w = l_instr; a = {3'b0, l_addr}; d = l_done; end
      endcase
      if (v && ready) begin
        got_w.push_back(w);
        got_a.push_back(a);
      end
      if (d) got_done++;
      $display("collect inst=%0d cyc=%0d valid=%0b ready=%0b addr=%0d word=%02h done=%0b",
               which, c, v, ready, a, w, d);
      tick();
    end
  endtask

  task automatic compare_got(input string name);
    chk({name, "_count"}, 32'(got_w.size()), 32'(ew.size()));
    for (int i = 0; i < ew.size(); i++) begin
      if (i < got_w.size()) begin
        chk({name, "_word"}, 32'(got_w[i]), 32'(ew[i]));
        chk({name, "_addr"}, 32'(got_a[i]), 32'(ea_q[i]));
      end
    end
  endtask

  task automatic set_std_exp();
    ew = '{8'h45, 8'h59, 8'h18, 8'hC3};
    ea_q = '{5'd0, 5'd1, 5'd2, 5'd3};
  endtask

  // Scoreboard state for the randomized phase on u_ov.
  logic [7:0] mm [4];
  logic [9:0] expq[$];
  bit         run_m, done_m, ovr_m, kind_ovr;
  int         age;

  task automatic random_phase(input int ncyc);
    logic       pv, pr, pa;
    logic [7:0] pi;
    logic [1:0] pad;
    logic       hs, was_run, last;
    pv = 1'b0; pr = 1'b0; pa = 1'b0; pi = '0; pad = '0;
    run_m = 0; done_m = 0; ovr_m = 0; age = 0; expq.delete();
    for (int c = 0; c < ncyc; c++) begin
      chk("rnd_busy", 32'(o_busy), 32'(run_m));
      chk("rnd_valid", 32'(o_valid), 32'(run_m && age >= 2));
      chk("rnd_done", 32'(o_done), 32'(done_m));
      chk("rnd_overrun", 32'(o_ovr), 32'(ovr_m));
      if (pv && !pr && !pa) begin
        chk("rnd_hold_word", 32'(o_instr), 32'(pi));
        chk("rnd_hold_addr", 32'(o_addr), 32'(pad));
      end
      if (c < 4) begin
        prog_we = 1'b1; prog_addr = 5'(c); prog_data = 8'($urandom);
        start = 1'b0; abort = 1'b0;
      end else begin
        prog_we   = ($urandom_range(3) == 0);
        prog_addr = 5'($urandom);
        prog_data = 8'($urandom);
        start     = ($urandom_range(5) == 0);
        abort     = ($urandom_range(39) == 0);
      end
      ready = ($urandom_range(2) != 0);
      hs = o_valid && ready;
      if (hs) begin
        chk("rnd_expected_word", 32'(expq.size() > 0), 1);
        if (expq.size() > 0) chk("rnd_word", 32'({o_addr, o_instr}), 32'(expq[0]));
        $display("rnd cyc=%0d handshake addr=%0d word=%02h", c, o_addr, o_instr);
      end
      pv = o_valid; pr = ready; pa = abort; pi = o_instr; pad = o_addr;
      tick();
      was_run = run_m;
      last = 1'b0;
      if (hs && expq.size() > 0) begin
        void'(expq.pop_front());
        last = (expq.size() == 0);
      end
      done_m = 0;
      if (!was_run && prog_we) mm[prog_addr[1:0]] = prog_data;
      if (abort) begin
        run_m = 0;
        expq.delete();
      end else if (was_run) begin
        age++;
        if (last) begin
          run_m = 0;
          if (kind_ovr) ovr_m = 1; else done_m = 1;
        end
      end else if (start) begin
        run_m = 1; age = 1; ovr_m = 0; kind_ovr = 1;
        for (int k = 0; k < 4; k++) begin
          expq.push_back({2'(k), mm[k]});
          if (mm[k][7:6] == OP_STOP) begin
            kind_ovr = 0;
            break;
          end
        end
      end
    end
    prog_we = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  initial begin
    // REQ-038 then REQ-039 (ready low 3 cycles on word 1), one row per cycle.
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h45, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h59, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h18, 2, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'hC3, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 8'h00, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h45, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h59, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h59, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 8'h59, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h59, 1, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'h18, 2, 1, 0));
    vecs.push_back(mk(0, 1, 1, 8'hC3, 3, 1, 0));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 8'h00, 0, 0, 0));

    clear = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; abort = 1'b0; ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_instr", 32'(m_instr), 0);
    chk("rst_addr", 32'(m_addr), 0);
    chk("rst_done", 32'(m_done), 0);
    chk("rst_overrun", 32'(m_ovr), 0);
    chk("rst_busy", 32'(m_busy), 0);
    clear = 1'b0;
    load_std();

    foreach (vecs[i]) begin
      chk("tbl_valid", 32'(m_valid), 32'(vecs[i].ev));
      chk("tbl_busy", 32'(m_busy), 32'(vecs[i].eb));
      chk("tbl_done", 32'(m_done), 32'(vecs[i].ed));
      chk("tbl_overrun", 32'(m_ovr), 0);
      if (vecs[i].ev) begin
        chk("tbl_instr", 32'(m_instr), 32'(vecs[i].ei));
        chk("tbl_addr", 32'(m_addr), 32'(vecs[i].ea));
      end
      $display("tbl row=%0d valid=%0b instr=%02h addr=%0d busy=%0b done=%0b",
               i, m_valid, m_instr, m_addr, m_busy, m_done);
      start = vecs[i].s; ready = vecs[i].r;
      tick();
      start = 1'b0;
    end

    // Write and start in the same idle cycle: first fetch sees the new word.
    prog_we = 1'b1; prog_addr = 5'd0; prog_data = 8'h7A; start = 1'b1; ready = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    chk("wrstart_n1_valid", 32'(m_valid), 0);
    chk("wrstart_n1_busy", 32'(m_busy), 1);
    tick();
    chk("wrstart_n2_valid", 32'(m_valid), 1);
    chk("wrstart_n2_instr", 32'(m_instr), 32'h7A);
    chk("wrstart_n2_addr", 32'(m_addr), 0);
    $display("wrstart valid=%0b instr=%02h addr=%0d", m_valid, m_instr, m_addr);
    repeat (8) tick();
    chk("wrstart_idle", 32'(m_busy), 0);
    load(5'd0, 8'h45);

    // Write during RUN is dropped; run ends at the original stop.
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    prog_we = 1'b1; prog_addr = 5'd2; prog_data = 8'hC3;
    tick();
    prog_we = 1'b0;
    collect(0, 8);
    set_std_exp();
    compare_got("runwr");
    chk("runwr_done", 32'(got_done), 1);

    // LOOP=1 wraps until abort; LOOP=0 overruns after four words.
    load(5'd0, 8'h05); load(5'd1, 8'h46); load(5'd2, 8'h87); load(5'd3, 8'h1C);
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    collect(2, 14);
    ew.delete(); ea_q.delete();
    for (int i = 0; i < 13; i++) begin
      logic [7:0] prog4 [4];
      prog4 = '{8'h05, 8'h46, 8'h87, 8'h1C};
      ew.push_back(prog4[i % 4]);
      ea_q.push_back(5'(i % 4));
    end
    compare_got("loop");
    chk("loop_done", 32'(got_done), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("loop_abort_valid", 32'(l_valid), 0);
    chk("loop_abort_busy", 32'(l_busy), 0);
    chk("loop_abort_done", 32'(l_done), 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    collect(1, 10);
    ew = '{8'h05, 8'h46, 8'h87, 8'h1C};
    ea_q = '{5'd0, 5'd1, 5'd2, 5'd3};
    compare_got("ovr");
    chk("ovr_done", 32'(got_done), 0);
    chk("ovr_flag", 32'(o_ovr), 1);
    chk("ovr_busy", 32'(o_busy), 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Abort beats start in IDLE, and overrun stays sticky.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abstart_busy", 32'(m_busy), 0);
    chk("abstart_ovr_busy", 32'(o_busy), 0);
    chk("abstart_ovr_sticky", 32'(o_ovr), 1);
    tick();
    chk("abstart_valid", 32'(m_valid), 0);

    // Abort with a word pending, then async clear mid-run, then a fresh run.
    load_std();
    start = 1'b1; ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("pend_valid", 32'(m_valid), 1);
    chk("pend_addr", 32'(m_addr), 0);
    tick();
    chk("pend_hold", 32'(m_instr), 32'h45);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 32'(m_valid), 0);
    chk("abort_busy", 32'(m_busy), 0);
    chk("abort_done", 32'(m_done), 0);
    chk("abort_overrun", 32'(m_ovr), 0);
    tick();
    chk("abort_done_late", 32'(m_done), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("preclr_valid", 32'(m_valid), 1);
    #2 clear = 1'b1;
    #1;
    chk("clr_valid", 32'(m_valid), 0);
    chk("clr_busy", 32'(m_busy), 0);
    chk("clr_instr", 32'(m_instr), 0);
    @(posedge clk);
    #1 clear = 1'b0;
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    collect(0, 8);
    set_std_exp();
    compare_got("rerun");
    chk("rerun_done", 32'(got_done), 1);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    random_phase(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_W, default 8: instruction width in bits; opcode is bits [INSTR_W-1:INSTR_W-2].
REQ-002 SHALL have parameter DEPTH, default 32: program memory entries; ADDR_W = clog2(DEPTH).
REQ-003 SHALL have parameter LOOP, default 0: 1 means wrap to address 0 after the last entry; 0 means overrun halt.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 clear  input  1  asynchronous active-high reset.
REQ-007 prog_we  input  1  program-memory write strobe.
REQ-008 prog_addr  input  ADDR_W  program write address.
REQ-009 prog_data  input  INSTR_W  program write data.
REQ-010 start  input  1  run request, single-cycle pulse.
REQ-011 abort  input  1  stop run immediately.
REQ-012 instr_ready  input  1  consumer accepts instruction.
REQ-013 instr_valid  output  1  instruction port holds a valid word.
REQ-014 instruction  output  INSTR_W  fetched instruction.
REQ-015 address  output  ADDR_W  memory address of the word on instruction.
REQ-016 busy  output  1  high in RUN and DRAIN.
REQ-017 done  output  1  one-cycle pulse on normal completion.
REQ-018 overrun  output  1  sticky; set when LOOP=0 and the end of memory is reached with no stop.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN.
REQ-020 IDLE: start=1 SHALL clear the PC to 0 and overrun to 0, then go to RUN; start SHALL be ignored outside IDLE.
REQ-021 prog_we SHALL write mem[prog_addr] only in IDLE; writes while busy SHALL be dropped.
REQ-022 The RUN fetch condition is (!instr_valid || instr_ready). On a fetch, mem[pc] SHALL be registered onto instruction, address<=pc, instr_valid<=1, and pc<=pc+1.
REQ-023 Latency: start in cycle N SHALL produce instr_valid=1 with mem[0] in cycle N+2.
REQ-024 A write and a start in the same IDLE cycle SHALL both take effect, and the first fetch SHALL see the written data.
REQ-025 Handshake: instruction and address SHALL hold stable while instr_valid && !instr_ready.
REQ-026 With back-to-back readiness, the block SHALL transfer one instruction per cycle.
REQ-027 If the fetched word has opcode 2'b11 (stop), it SHALL be presented and the FSM SHALL enter DRAIN with no further fetches.
REQ-028 DRAIN: on handshake, instr_valid<=0, done pulses for 1 cycle, and the FSM returns to IDLE.
REQ-029 A fetch from DEPTH-1 with no stop SHALL, when LOOP=1, wrap the PC to 0 and continue.
REQ-030 A fetch from DEPTH-1 with no stop SHALL, when LOOP=0, behave as stop: go to DRAIN, then set overrun in place of the done pulse.
REQ-031 abort in any state SHALL, at the next edge, force IDLE with instr_valid=0, no done, and overrun unchanged.
REQ-032 abort together with start in IDLE: abort SHALL win.

Reset
REQ-033 clear SHALL asynchronously force state=IDLE, pc=0, address=0, instruction=0, instr_valid=0, done=0, overrun=0.
REQ-034 clear SHALL NOT initialise memory contents.
REQ-035 clear asserted mid-run SHALL drop any pending instruction without a handshake.

Structure
REQ-036 A shared package SHALL hold the opcode constants OP_ADD=2'b00, OP_LOAD=2'b01, OP_STORE=2'b10, OP_STOP=2'b11, plus the state enum.
REQ-037 Program memory SHALL be a sub-module prog_mem: synchronous write, combinational read, parametrised by INSTR_W and DEPTH.

Verification
REQ-038 Load 01000101, 01011001, 00011000, 11000011 at 0..3, hold ready=1, start -> outputs at addresses 0,1,2,3 on consecutive cycles from N+2, then done one cycle after the 11000011 handshake.
REQ-039 Same program with ready low for 3 cycles on word 1 -> 01011001 and address=1 held stable; no word lost or duplicated.
REQ-040 LOOP=0, DEPTH=4, no stop word -> 4 words transferred, overrun=1, done never pulses; LOOP=1 -> address sequence 0,1,2,3,0,1... until abort.
REQ-041 prog_we to address 2 with data 11000011 during RUN -> memory unchanged, and the run completes at the original stop.
REQ-042 abort while a word is pending, then clear mid-run -> instr_valid=0 next edge/immediately, busy=0, and a fresh start re-runs from address 0.
